word_uart_tx: RTL and testbench

WORD_UART_TX -- requirements
Module: word_uart_tx

---
 rtl/word_uart_tx.sv | 104 ++++++++++
 tb/tb_word_uart_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_uart_tx.sv
// 32-bit word to 8N1 UART serializer: four bytes MSB-byte first, bits LSB first,
// with back-to-back bytes and a one-cycle word_done pulse after the last stop bit.
module word_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx,
  output logic        busy,
  output logic        word_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  baud_cnt, baud_nxt;
  logic [2:0]        bit_cnt, bit_nxt;
  logic [1:0]        byte_cnt, byte_nxt;
  logic [31:0]       shreg, shreg_nxt;
  logic [7:0]        byte_cur;
  logic              done_nxt;
  logic              bit_end;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign byte_cur = shreg[31:24];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      word_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      byte_cnt  <= byte_nxt;
      shreg     <= shreg_nxt;
      word_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    byte_nxt  = byte_cnt;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;
    tx        = 1'b1;

    // Baud counter runs in every non-idle state and reloads at each bit boundary.
    if (state != IDLE)
      baud_nxt = bit_end ? '0 : baud_cnt + CNT_W'(1);

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_nxt = START;
          shreg_nxt = in_data;
          baud_nxt  = '0;
          bit_nxt   = '0;
          byte_nxt  = '0;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        tx = byte_cur[bit_cnt];
        if (bit_end) begin
          bit_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          byte_nxt  = byte_cnt + 2'd1;
          shreg_nxt = shreg << 8;
          if (byte_cnt == 2'd3) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = START;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_word_uart_tx.sv
// Bench for word_uart_tx: one instance at CLKS_PER_BIT=4 and one at 1, checked
// cycle by cycle against a frame model computed from the 8N1 framing rules.
`timescale 1ns/1ps
module tb_word_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] in_data = '0;
  logic        valid_a, valid_b;
  logic        ready_a, tx_a, busy_a, done_a;
  logic        ready_b, tx_b, busy_b, done_b;
  logic        ready_s, tx_s, busy_s, done_s;
  int          errors = 0;
  int          checks = 0;
  bit          scramble = 1'b0;

  always #5 clk = ~clk;

  assign valid_a = in_valid & ~sel;
  assign valid_b = in_valid & sel;
  assign ready_s = sel ? ready_b : ready_a;
  assign tx_s    = sel ? tx_b    : tx_a;
  assign busy_s  = sel ? busy_b  : busy_a;
  assign done_s  = sel ? done_b  : done_a;

  word_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_a),
    .in_ready(ready_a), .tx(tx_a), .busy(busy_a), .word_done(done_a));

  word_uart_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid_b),
    .in_ready(ready_b), .tx(tx_b), .busy(busy_b), .word_done(done_b));

  // Expected line level t cycles after the acceptance edge of word w.
  function automatic logic exp_tx(input logic [31:0] w, input int cpb, input int t);
    int period, byte_i, pos;
    logic [7:0] b;
    period = t / cpb;
    byte_i = period / 10;
    pos    = period % 10;
    b      = 8'(w >> (24 - 8 * byte_i));
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_word(input logic [31:0] w);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Entered just after the acceptance edge; leaves on the word_done cycle.
  task automatic run_frame(input logic [31:0] w, input string tag);
    int cpb;
    cpb = sel ? 1 : 4;
    for (int t = 0; t < 40 * cpb; t++) begin
      if (scramble) in_data = $urandom;
      checks++;
      if (tx_s !== exp_tx(w, cpb, t)) begin
        errors++;
        $display("FAIL %s tx t=%0d word=%h got=%b exp=%b", tag, t, w, tx_s, exp_tx(w, cpb, t));
      end
      checks++;
      if ({ready_s, busy_s, done_s} !== 3'b010) begin
        errors++;
        $display("FAIL %s status t=%0d ready/busy/done got=%b exp=010", tag, t, {ready_s, busy_s, done_s});
      end
      tick();
    end
    checks++;
    if ({tx_s, ready_s, busy_s, done_s} !== 4'b1101) begin
      errors++;
      $display("FAIL %s done_cycle tx/ready/busy/done got=%b exp=1101", tag, {tx_s, ready_s, busy_s, done_s});
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({tx_s, ready_s, busy_s, done_s} !== 4'b1100) begin
        errors++;
        $display("FAIL reset_state sel=%0d tx/ready/busy/done got=%b exp=1100", s, {tx_s, ready_s, busy_s, done_s});
      end
    end
    sel = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if ({tx_s, ready_s, busy_s, done_s} !== 4'b1100) begin
      errors++;
      $display("FAIL after_reset tx/ready/busy/done got=%b exp=1100", {tx_s, ready_s, busy_s, done_s});
    end
  endtask

  task automatic test_basic;
    sel = 1'b0;
    #1;
    start_word(32'hA5C30F81);
    run_frame(32'hA5C30F81, "basic");
    tick();
    checks++;
    if ({tx_s, ready_s, done_s} !== 3'b110) begin
      errors++;
      $display("FAIL basic_pulse_len tx/ready/done got=%b exp=110", {tx_s, ready_s, done_s});
    end
  endtask

  task automatic test_hold_valid;
    logic [31:0] w1, w2;
    sel = 1'b0;
    #1;
    w1 = $urandom;
    w2 = $urandom;
    in_data  = w1;
    in_valid = 1'b1;
    tick();
    in_data = w2;
    run_frame(w1, "hold_w1");
    tick();
    in_valid = 1'b0;
    run_frame(w2, "hold_w2");
    tick();
    checks++;
    if ({tx_s, ready_s, done_s} !== 3'b110) begin
      errors++;
      $display("FAIL hold_no_third tx/ready/done got=%b exp=110", {tx_s, ready_s, done_s});
    end
  endtask

  task automatic test_data_change;
    logic [31:0] w;
    sel = 1'b0;
    #1;
    w = $urandom;
    start_word(w);
    scramble = 1'b1;
    run_frame(w, "scramble");
    scramble = 1'b0;
    tick();
  endtask

  task automatic test_reset_midway;
    sel = 1'b0;
    #1;
    start_word($urandom);
    repeat (62) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({tx_s, ready_s, busy_s, done_s} !== 4'b1100) begin
      errors++;
      $display("FAIL mid_reset tx/ready/busy/done got=%b exp=1100", {tx_s, ready_s, busy_s, done_s});
    end
    for (int i = 0; i < 200; i++) begin
      tick();
      checks++;
      if ({tx_s, ready_s, done_s} !== 3'b110) begin
        errors++;
        $display("FAIL mid_reset_abandon cyc=%0d tx/ready/done got=%b exp=110", i, {tx_s, ready_s, done_s});
      end
    end
    start_word(32'h00000000);
    run_frame(32'h00000000, "post_reset");
    tick();
  endtask

  task automatic test_cpb1;
    sel = 1'b1;
    #1;
    start_word(32'hFFFFFFFF);
    run_frame(32'hFFFFFFFF, "cpb1_ones");
    in_data  = 32'h00000000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    run_frame(32'h00000000, "cpb1_zeros");
    tick();
    sel = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] w;
    int gap;
    for (int n = 0; n < 10; n++) begin
      sel = (n >= 5);
      #1;
      w = $urandom;
      start_word(w);
      run_frame(w, sel ? "rand_cpb1" : "rand_cpb4");
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) begin
        tick();
        checks++;
        if ({tx_s, ready_s, done_s} !== 3'b110) begin
          errors++;
          $display("FAIL rand_gap n=%0d tx/ready/done got=%b exp=110", n, {tx_s, ready_s, done_s});
        end
      end
      if (gap == 0 && n == 4) tick();
    end
    tick();
    sel = 1'b0;
  endtask

  task automatic test_reset_with_valid;
    sel = 1'b0;
    #1;
    in_data  = $urandom;
    in_valid = 1'b1;
    rst      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({tx_s, ready_s, busy_s, done_s} !== 4'b1100) begin
        errors++;
        $display("FAIL rst_valid i=%0d tx/ready/busy/done got=%b exp=1100", i, {tx_s, ready_s, busy_s, done_s});
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    checks++;
    if ({tx_s, done_s} !== 2'b10) begin
      errors++;
      $display("FAIL rst_valid_after tx/done got=%b exp=10", {tx_s, done_s});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    #2;
    test_reset();
    test_basic();
    test_hold_valid();
    test_data_change();
    test_reset_midway();
    test_cpb1();
    test_random();
    test_reset_with_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
